mux_scan_ctrl: RTL

- Upstream sequencer for the team's 4:1 single-bit mux (inputs a,b,c,d; selects s0,s1; output s).
- Steps the select lines through all four channels, waits a programmable settle time on each, and samples the mux output.
- Packs the four samples into a 4-bit word and hands it downstream with a valid/ready handshake.
- Turns the combinational mux into a scanned 4-channel input port.

---
 rtl/mux_scan_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 single-bit mux: steps the selects through all four channels,
// samples each after a settle time, and hands the packed 4-bit word downstream on valid/ready.
module mux_scan_ctrl #(
    parameter int DWELL = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mux_in,
    output logic             s0,
    output logic             s1,
    output logic [3:0]       word,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic [CNT_W-1:0] scan_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam logic [3:0] RELOAD = 4'(DWELL - 1);

    if ((DWELL < 1) || (DWELL > 15)) begin : g_bad_dwell
        $error("mux_scan_ctrl: DWELL must be within 1..15");
    end

    logic [1:0]       r_state;
    logic [1:0]       r_idx;
    logic [3:0]       r_cnt;
    logic [2:0]       r_shadow;
    logic [3:0]       r_word;
    logic             r_valid;
    logic             r_busy;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_scan_cnt;

    logic [1:0]       w_nxt_state;
    logic [1:0]       w_nxt_idx;
    logic [3:0]       w_nxt_cnt;
    logic [2:0]       w_nxt_shadow;
    logic [3:0]       w_nxt_word;
    logic [CNT_W-1:0] w_nxt_scan_cnt;

    // Next-state and datapath update for the scan sequencer.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_idx      = r_idx;
        w_nxt_cnt      = r_cnt;
        w_nxt_shadow   = r_shadow;
        w_nxt_word     = r_word;
        w_nxt_scan_cnt = r_scan_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nxt_state = ST_SETTLE;
                    w_nxt_idx   = 2'd0;
                    w_nxt_cnt   = RELOAD;
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt != 4'd0) begin
                    w_nxt_cnt = r_cnt - 4'd1;
                end else if (r_idx != 2'd3) begin
                    case (r_idx)
                        2'd0:    w_nxt_shadow[0] = mux_in;
                        2'd1:    w_nxt_shadow[1] = mux_in;
                        2'd2:    w_nxt_shadow[2] = mux_in;
                        default: w_nxt_shadow    = r_shadow;
                    endcase
                    w_nxt_idx = r_idx + 2'd1;
                    w_nxt_cnt = RELOAD;
                end else begin
                    // Last channel goes straight into the word; no need to park it in the shadow.
                    w_nxt_word  = {mux_in, r_shadow};
                    w_nxt_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ready) begin
                    w_nxt_scan_cnt = r_scan_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (start) begin
                        w_nxt_state = ST_SETTLE;
                        w_nxt_idx   = 2'd0;
                        w_nxt_cnt   = RELOAD;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    w_nxt_state = ST_HOLD;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_idx   = 2'd0;
                w_nxt_cnt   = 4'd0;
            end
        endcase
    end

    // State registers; outputs are registered from the next state so no input reaches them combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idx      <= 2'd0;
            r_cnt      <= 4'd0;
            r_shadow   <= 3'd0;
            r_word     <= 4'd0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_sel      <= 2'd0;
            r_scan_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state    <= w_nxt_state;
            r_idx      <= w_nxt_idx;
            r_cnt      <= w_nxt_cnt;
            r_shadow   <= w_nxt_shadow;
            r_word     <= w_nxt_word;
            r_valid    <= (w_nxt_state == ST_HOLD);
            r_busy     <= (w_nxt_state == ST_SETTLE) || (w_nxt_state == ST_HOLD);
            r_sel      <= (w_nxt_state == ST_SETTLE) ? w_nxt_idx : 2'd0;
            r_scan_cnt <= w_nxt_scan_cnt;
        end
    end

    assign s0       = r_sel[0];
    assign s1       = r_sel[1];
    assign word     = r_word;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign scan_cnt = r_scan_cnt;

endmodule
